// File: rtl/ifu_fetch.sv
// Instruction fetch unit: fetch PC register, combinational-read instruction memory port and
// a DEPTH-entry fetch buffer. Optional PC range check enabled by macro IFU_PC_RANGE_CHECK_EN.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      pc_mem_q    [DEPTH];
   logic             push_s;
   logic             pop_s;
   logic             redirect_unused_s;

`ifdef IFU_PC_RANGE_CHECK_EN
   logic             fault_mem_q [DEPTH];

   function automatic logic pc_out_of_range(input logic [31:0] pc);
      return (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
   endfunction
`endif

   // Targets are word aligned; the low redirect bits are intentionally dropped.
   assign redirect_unused_s = ^redirect_pc[1:0];

   assign imem_addr = pc_q;
   assign out_valid = (count_q != CNT_ZERO);
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];

`ifdef IFU_PC_RANGE_CHECK_EN
   assign out_fault = fault_mem_q[rd_ptr_q];
`else
   assign out_fault = 1'b0;
`endif

   // Handshake decode: a pop frees a slot for the same-cycle push; redirect blocks the push.
   always_comb begin
      pop_s  = out_valid && out_ready;
      push_s = 1'b0;
      if (!redirect_valid && ((count_q < DEPTH_C) || pop_s)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
   end

   // Next-state for PC, pointers and occupancy.
   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         rd_ptr_d = PTR_ZERO;
         wr_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
      end else begin
         if (push_s) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            pc_d     = pc_q;
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         rd_ptr_q <= PTR_ZERO;
         wr_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Buffer storage; cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= 32'd0;
            pc_mem_q[i]    <= 32'd0;
         end
      end else if (push_s) begin
         instr_mem_q[wr_ptr_q] <= imem_instr;
         pc_mem_q[wr_ptr_q]    <= pc_q;
      end else begin
         instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
         pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
      end
   end

`ifdef IFU_PC_RANGE_CHECK_EN
   // Fault bit storage, tagged at push time from the fetch PC.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fault_mem_q[i] <= 1'b0;
         end
      end else if (push_s) begin
         fault_mem_q[wr_ptr_q] <= pc_out_of_range(pc_q);
      end else begin
         fault_mem_q[wr_ptr_q] <= fault_mem_q[wr_ptr_q];
      end
   end
`endif

endmodule
